fpu_share_arbiter: RTL and testbench

- Shares one pipelined floating-point adder (recoded HardFloat format, fixed latency) between several accumulator requesters inside the FIR filter, e.g. the lookahead and lookback partial-sum chains.
- Arbitrates issue slots round-robin and tags every operation.
- Routes each result back to its originating requester.
- Bounds the number of in-flight operations per requester with credit counters.

---
 rtl/fpu_share_pkg.sv | 20 ++
 rtl/fpu_share_arbiter_rr_arbiter.sv | 32 +++
 rtl/fpu_share_arbiter.sv | 139 +++++++++++++
 tb/tb_fpu_share_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_share_pkg.sv
// Shared types for the FPU-sharing arbiter: requester tags, tag-pipeline stages,
// and the credit counter sizing helper.
package fpu_share_pkg;

  // Tags are sized for the largest supported requester count so one type serves every instance.
  localparam int MAX_REQ = 8;
  localparam int TAG_W   = $clog2(MAX_REQ);

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic valid;
    tag_t tag;
  } tag_stage_t;

  function automatic int creditWidth(input int maxOut);
    return $clog2(maxOut + 1);
  endfunction

endpackage

// File: rtl/fpu_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to index 0.
module rr_arbiter
  import fpu_share_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] reqVec,
  input  tag_t             ptr,
  output logic [N_REQ-1:0] grant
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && reqVec[i] && (tag_t'(i) >= ptr)) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    // Second pass covers the wrap-around below the pointer.
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && reqVec[i] && (tag_t'(i) < ptr)) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_share_arbiter.sv
// Shares one fixed-latency pipelined adder between N_REQ accumulator requesters:
// round-robin issue, tag tracking alongside the adder, result routing and per-requester credits.
module fpu_share_arbiter
  import fpu_share_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = 24,
  parameter int ADD_LAT = 3,
  parameter int MAX_OUT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic                    fpu_valid,
  output logic [DATA_W-1:0]       fpu_a,
  output logic [DATA_W-1:0]       fpu_b,
  input  logic [DATA_W-1:0]       fpu_res,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    busy
);

  localparam int               CNT_W      = creditWidth(MAX_OUT);
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(MAX_OUT);
  localparam tag_t             LAST_REQ   = tag_t'(N_REQ - 1);

  tag_t              rrPtr;
  tag_t              grantIdx;
  tag_t              issueTag;
  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  grant;
  logic              handshake;
  logic [DATA_W-1:0] selA;
  logic [DATA_W-1:0] selB;
  logic [CNT_W-1:0]  outstanding [N_REQ];
  tag_stage_t        tagPipe [ADD_LAT];
  tag_stage_t        tagOut;
  logic [N_REQ-1:0]  rspNext;

  // A response leaving this cycle returns its credit immediately, so a requester
  // at its limit can reissue in the same cycle without a bubble.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req_valid[i] && ((outstanding[i] < CREDIT_MAX) || rsp_valid[i]);
    end
  end

  rr_arbiter #(.N_REQ(N_REQ)) uArb (
    .reqVec (eligible),
    .ptr    (rrPtr),
    .grant  (grant)
  );

  // Handshake: a transfer happens exactly when req_valid[i] & req_ready[i] in a cycle;
  // ready never depends on anything but eligibility, and is held low during reset.
  assign req_ready = rst ? '0 : grant;
  assign handshake = |(req_valid & req_ready);

  always_comb begin
    grantIdx = '0;
    selA     = '0;
    selB     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        grantIdx = tag_t'(i);
        selA     = req_a[i*DATA_W +: DATA_W];
        selB     = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr     <= '0;
      fpu_valid <= 1'b0;
      fpu_a     <= '0;
      fpu_b     <= '0;
      issueTag  <= '0;
    end else begin
      fpu_valid <= handshake;
      if (handshake) begin
        rrPtr    <= (grantIdx == LAST_REQ) ? '0 : grantIdx + 1'b1;
        fpu_a    <= selA;
        fpu_b    <= selB;
        issueTag <= grantIdx;
      end
    end
  end

  // The last stage lines up with the cycle the adder presents the matching result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < ADD_LAT; s++) tagPipe[s] <= '0;
    end else begin
      tagPipe[0] <= {fpu_valid, issueTag};
      for (int s = 1; s < ADD_LAT; s++) tagPipe[s] <= tagPipe[s-1];
    end
  end

  assign tagOut = tagPipe[ADD_LAT-1];

  always_comb begin
    rspNext = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (tagOut.valid && (tagOut.tag == tag_t'(i))) rspNext[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= rspNext;
      if (tagOut.valid) rsp_data <= fpu_res;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) outstanding[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_ready[i] && !rsp_valid[i]) outstanding[i] <= outstanding[i] + 1'b1;
        else if (!req_ready[i] && rsp_valid[i]) outstanding[i] <= outstanding[i] - 1'b1;
      end
    end
  end

  always_comb begin
    busy = fpu_valid | (|rsp_valid);
    for (int s = 0; s < ADD_LAT; s++) busy = busy | tagPipe[s].valid;
  end

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Bench for fpu_share_arbiter: three instances (N=2/MAX_OUT=4, N=2/MAX_OUT=2, N=3/MAX_OUT=8)
// each driven against an integer-add model of the fixed-latency adder.
module tb_fpu_share_arbiter;

  localparam int DW  = 24;
  localparam int LAT = 3;
  localparam int SBW = 16 + 2 + DW;

  // Operands are opaque to the block; the model adder sums them as integers.
  localparam logic [DW-1:0] OP_ONE = 24'h080000;
  localparam logic [DW-1:0] OP_TWO = 24'h081000;
  localparam logic [DW-1:0] OP_SUM = 24'h101000;

  typedef struct {
    logic [1:0] valid;
    logic [1:0] expReady;
    logic       expFpuValid;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic [SBW-1:0] exp_q[$];

  logic [1:0]      aReqValid, aReqReady, aRspValid;
  logic [2*DW-1:0] aReqA, aReqB;
  logic            aFpuValid, aBusy;
  logic [DW-1:0]   aFpuA, aFpuB, aFpuRes, aRspData;
  logic [DW-1:0]   aPipe [LAT];

  logic [1:0]      bReqValid, bReqReady, bRspValid;
  logic [2*DW-1:0] bReqA, bReqB;
  logic            bFpuValid, bBusy;
  logic [DW-1:0]   bFpuA, bFpuB, bFpuRes, bRspData;
  logic [DW-1:0]   bPipe [LAT];

  logic [2:0]      cReqValid, cReqReady, cRspValid;
  logic [3*DW-1:0] cReqA, cReqB;
  logic            cFpuValid, cBusy;
  logic [DW-1:0]   cFpuA, cFpuB, cFpuRes, cRspData;
  logic [DW-1:0]   cPipe [LAT];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs and adder models ----------------
  fpu_share_arbiter #(.N_REQ(2), .DATA_W(DW), .ADD_LAT(LAT), .MAX_OUT(4)) dutA (
    .clk(clk), .rst(rst), .req_valid(aReqValid), .req_ready(aReqReady),
    .req_a(aReqA), .req_b(aReqB), .fpu_valid(aFpuValid), .fpu_a(aFpuA), .fpu_b(aFpuB),
    .fpu_res(aFpuRes), .rsp_valid(aRspValid), .rsp_data(aRspData), .busy(aBusy)
  );

  fpu_share_arbiter #(.N_REQ(2), .DATA_W(DW), .ADD_LAT(LAT), .MAX_OUT(2)) dutB (
    .clk(clk), .rst(rst), .req_valid(bReqValid), .req_ready(bReqReady),
    .req_a(bReqA), .req_b(bReqB), .fpu_valid(bFpuValid), .fpu_a(bFpuA), .fpu_b(bFpuB),
    .fpu_res(bFpuRes), .rsp_valid(bRspValid), .rsp_data(bRspData), .busy(bBusy)
  );

  fpu_share_arbiter #(.N_REQ(3), .DATA_W(DW), .ADD_LAT(LAT), .MAX_OUT(8)) dutC (
    .clk(clk), .rst(rst), .req_valid(cReqValid), .req_ready(cReqReady),
    .req_a(cReqA), .req_b(cReqB), .fpu_valid(cFpuValid), .fpu_a(cFpuA), .fpu_b(cFpuB),
    .fpu_res(cFpuRes), .rsp_valid(cRspValid), .rsp_data(cRspData), .busy(cBusy)
  );

  always @(posedge clk) begin
    aPipe[0] <= aFpuA + aFpuB;
    bPipe[0] <= bFpuA + bFpuB;
    cPipe[0] <= cFpuA + cFpuB;
    for (int k = 1; k < LAT; k++) begin
      aPipe[k] <= aPipe[k-1];
      bPipe[k] <= bPipe[k-1];
      cPipe[k] <= cPipe[k-1];
    end
  end

  assign aFpuRes = aPipe[LAT-1];
  assign bFpuRes = bPipe[LAT-1];
  assign cFpuRes = cPipe[LAT-1];

  // ---------------- driver / check tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    aReqValid = '0;
    bReqValid = '0;
    cReqValid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic randOpsA();
    aReqA = {DW'($urandom_range(0, 32'hFFFFFF)), DW'($urandom_range(0, 32'hFFFFFF))};
    aReqB = {DW'($urandom_range(0, 32'hFFFFFF)), DW'($urandom_range(0, 32'hFFFFFF))};
  endtask

  task automatic drainA();
    int n;
    n = 0;
    @(negedge clk);
    while (aBusy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain_idle", aBusy, 0);
    check("drain_sb_empty", exp_q.size(), 0);
    nextCycle();
  endtask

  // ---------------- scoreboard for dutA ----------------
  always @(negedge clk) begin
    logic [SBW-1:0] e;
    if (rst) begin
      exp_q.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (aReqValid[i] && aReqReady[i])
          exp_q.push_back({cyc[15:0], 2'(i), aReqA[i*DW +: DW] + aReqB[i*DW +: DW]});
      end
      if (aRspValid != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", aRspValid, 0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_route", aRspValid, 64'd1 << e[DW+1:DW]);
          check("rsp_data", aRspData, e[DW-1:0]);
          check("rsp_latency", cyc - int'(e[SBW-1:DW+2]), LAT + 2);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    vec_t vecs[8];
    int   grants[3];
    int   gaps[3];
    int   rspCnt[3];
    int   maxGap;
    int   oneHotErr;
    int   dataErr;

    aReqValid = 2'b11; aReqA = '0; aReqB = '0;
    bReqValid = '0;    bReqA = '0; bReqB = '0;
    cReqValid = '0;    cReqA = '0; cReqB = '0;

    vecs[0] = '{2'b00, 2'b00, 1'b0};
    vecs[1] = '{2'b10, 2'b10, 1'b0};
    vecs[2] = '{2'b11, 2'b01, 1'b1};
    vecs[3] = '{2'b11, 2'b10, 1'b1};
    vecs[4] = '{2'b01, 2'b01, 1'b1};
    vecs[5] = '{2'b01, 2'b01, 1'b1};
    vecs[6] = '{2'b11, 2'b10, 1'b1};
    vecs[7] = '{2'b00, 2'b00, 1'b1};

    // Reset state while requests are pending.
    @(negedge clk);
    check("reset_ready", aReqReady, 0);
    check("reset_fpu_valid", aFpuValid, 0);
    check("reset_rsp_valid", aRspValid, 0);
    check("reset_busy", aBusy, 0);
    check("reset_fpu_a", aFpuA, 0);
    check("reset_rsp_data", aRspData, 0);

    // Table of grant/issue vectors from a fresh reset.
    doReset();
    for (int k = 0; k < 8; k++) begin
      aReqValid = vecs[k].valid;
      randOpsA();
      @(negedge clk);
      check($sformatf("vec%0d_ready", k), aReqReady, vecs[k].expReady);
      check($sformatf("vec%0d_fpu_valid", k), aFpuValid, vecs[k].expFpuValid);
      nextCycle();
    end
    aReqValid = '0;
    drainA();

    // Single operation: issue, latency, result and busy timing.
    doReset();
    aReqValid = 2'b01;
    aReqA = {24'h0, OP_ONE};
    aReqB = {24'h0, OP_TWO};
    @(negedge clk);
    check("single_ready", aReqReady, 2'b01);
    nextCycle();
    aReqValid = '0;
    @(negedge clk);
    check("single_fpu_valid", aFpuValid, 1);
    check("single_fpu_a", aFpuA, OP_ONE);
    check("single_fpu_b", aFpuB, OP_TWO);
    for (int k = 2; k <= 4; k++) begin
      nextCycle();
      @(negedge clk);
      check("single_no_rsp_yet", aRspValid, 0);
      check("single_busy_mid", aBusy, 1);
    end
    nextCycle();
    @(negedge clk);
    check("single_rsp_valid", aRspValid, 2'b01);
    check("single_rsp_data", aRspData, OP_SUM);
    check("single_busy_rsp", aBusy, 1);
    nextCycle();
    @(negedge clk);
    check("single_busy_low", aBusy, 0);
    check("single_rsp_clear", aRspValid, 0);
    nextCycle();

    // Contention: grants alternate from reset, scoreboard checks routing and order.
    doReset();
    aReqValid = 2'b11;
    for (int k = 0; k < 20; k++) begin
      randOpsA();
      @(negedge clk);
      check("contend_ready", aReqReady, (k % 2 == 0) ? 2'b01 : 2'b10);
      nextCycle();
    end
    aReqValid = '0;
    drainA();

    // Requester 0 alone at MAX_OUT=4: stalls one cycle, then issues alongside each response.
    doReset();
    aReqValid = 2'b01;
    for (int k = 0; k < 15; k++) begin
      randOpsA();
      @(negedge clk);
      check("incdec_ready", aReqReady, (k % 5 != 4) ? 2'b01 : 2'b00);
      check("incdec_rsp", aRspValid, (k >= 5 && k % 5 != 4) ? 2'b01 : 2'b00);
      nextCycle();
    end
    aReqValid = '0;
    drainA();

    // Credit exhaustion at MAX_OUT=2 on requester 1.
    doReset();
    bReqValid = 2'b10;
    bReqA = {OP_ONE, 24'h0};
    bReqB = {OP_TWO, 24'h0};
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check("credit_ready", bReqReady, (k % 5 < 2) ? 2'b10 : 2'b00);
      check("credit_rsp", bRspValid, (k >= 5 && k % 5 < 2) ? 2'b10 : 2'b00);
      if (k >= 5 && k % 5 < 2) check("credit_rsp_data", bRspData, OP_SUM);
      nextCycle();
    end
    bReqValid = '0;
    repeat (8) nextCycle();
    @(negedge clk);
    check("credit_drain_busy", bBusy, 0);
    nextCycle();

    // Asynchronous reset with three operations in flight.
    doReset();
    aReqValid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      randOpsA();
      nextCycle();
    end
    #2 rst = 1'b1;
    #1;
    check("midrst_fpu_valid", aFpuValid, 0);
    check("midrst_rsp_valid", aRspValid, 0);
    check("midrst_busy", aBusy, 0);
    check("midrst_ready", aReqReady, 0);
    check("midrst_fpu_a", aFpuA, 0);
    aReqValid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("midrst_no_stale_rsp", aRspValid, 0);
      nextCycle();
    end
    aReqValid = 2'b11;
    randOpsA();
    @(negedge clk);
    check("midrst_first_grant", aReqReady, 2'b01);
    nextCycle();
    aReqValid = '0;
    drainA();

    // Fairness across three requesters over 300 cycles.
    doReset();
    cReqValid = 3'b111;
    cReqA = {OP_ONE, OP_ONE, OP_ONE};
    cReqB = {OP_TWO, OP_TWO, OP_TWO};
    maxGap = 0;
    oneHotErr = 0;
    dataErr = 0;
    for (int i = 0; i < 3; i++) begin
      grants[i] = 0;
      gaps[i]   = 0;
      rspCnt[i] = 0;
    end
    for (int k = 0; k < 310; k++) begin
      if (k == 300) cReqValid = '0;
      @(negedge clk);
      if (k < 300 && $countones(cReqReady) != 1) oneHotErr++;
      for (int i = 0; i < 3; i++) begin
        if (k < 300) begin
          if (cReqReady[i]) begin
            grants[i]++;
            gaps[i] = 0;
          end else begin
            gaps[i]++;
            if (gaps[i] > maxGap) maxGap = gaps[i];
          end
        end
        if (cRspValid[i]) begin
          rspCnt[i]++;
          if (cRspData !== OP_SUM) dataErr++;
        end
      end
      nextCycle();
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("fair_grants%0d", i), grants[i], 100);
      check($sformatf("fair_rsps%0d", i), rspCnt[i], 100);
    end
    check("fair_max_gap_le2", (maxGap <= 2) ? 1 : 0, 1);
    check("fair_one_hot", oneHotErr, 0);
    check("fair_rsp_data", dataErr, 0);
    check("fair_drain_busy", cBusy, 0);

    check("final_sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
